// File: rtl/rfphoenix_alu_opstage_if.sv
// Bundle of issue, writeback-forwarding and ALU-side signals for the operand stage.
// The slave modport is the stage itself; master is the issuer/ALU-side environment.
interface rfphoenix_alu_opstage_if #(
  parameter int IW = 40,
  parameter int VW = 32,
  parameter int RW = 6,
  parameter int TW = 2
);
  logic          iv;
  logic          irdy;
  logic [IW-1:0] iir;
  logic [TW-1:0] itag;
  logic [RW-1:0] iRa, iRb, iRc;
  logic [VW-1:0] ia, ib, ic;
  logic [VW-1:0] iimm;

  logic          wb0_v, wb1_v;
  logic [RW-1:0] wb0_Rt, wb1_Rt;
  logic [VW-1:0] wb0_res, wb1_res;

  logic          ov;
  logic          ordy;
  logic [IW-1:0] oir;
  logic [TW-1:0] otag;
  logic [VW-1:0] oa, ob, oc;
  logic [VW-1:0] oimm;

  modport slave (
    input  iv, iir, itag, iRa, iRb, iRc, ia, ib, ic, iimm,
    input  wb0_v, wb0_Rt, wb0_res, wb1_v, wb1_Rt, wb1_res,
    input  ordy,
    output irdy, ov, oir, otag, oa, ob, oc, oimm
  );

  modport master (
    output iv, iir, itag, iRa, iRb, iRc, ia, ib, ic, iimm,
    output wb0_v, wb0_Rt, wb0_res, wb1_v, wb1_Rt, wb1_res,
    output ordy,
    input  irdy, ov, oir, otag, oa, ob, oc, oimm
  );
endinterface

// File: rtl/rfphoenix_alu_opstage.sv
// ALU operand-latch stage: forwards writebacks into incoming and held operands, 2-entry skid.
// Optional perf counters (stall_cnt, fwd_cnt) built when RFPHOENIX_OPSTAGE_PERF_EN is defined.
module rfphoenix_alu_opstage #(
  parameter int IW = 40,
  parameter int VW = 32,
  parameter int RW = 6,
  parameter int TW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  rfphoenix_alu_opstage_if.slave bus
`ifdef RFPHOENIX_OPSTAGE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] fwd_cnt
`endif
);

  localparam int NOPS = 3;

  typedef struct packed {
    logic                      v;
    logic [IW-1:0]             ir;
    logic [TW-1:0]             tag;
    logic [NOPS-1:0][RW-1:0]   r;
    logic [NOPS-1:0][VW-1:0]   x;
    logic [VW-1:0]             imm;
  } ent_t;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] rt;
    logic [VW-1:0] res;
  } wb_t;

  // wb0 is the younger result, so it wins when both ports target the same register
  function automatic logic [VW-1:0] resolve(input logic [RW-1:0] rn, input logic [VW-1:0] cur,
                                            input wb_t w0, input wb_t w1);
    logic [VW-1:0] r;
    r = cur;
    if (rn == '0)                    r = '0;
    else if (w0.v && w0.rt == rn)    r = w0.res;
    else if (w1.v && w1.rt == rn)    r = w1.res;
    return r;
  endfunction

  function automatic logic hit(input logic [RW-1:0] rn, input wb_t w0, input wb_t w1);
    return (rn != '0) && ((w0.v && w0.rt == rn) || (w1.v && w1.rt == rn));
  endfunction

  function automatic ent_t snoop(input ent_t e, input wb_t w0, input wb_t w1);
    ent_t r;
    r = e;
    if (e.v)
      for (int k = 0; k < NOPS; k++) r.x[k] = resolve(e.r[k], e.x[k], w0, w1);
    return r;
  endfunction

  ent_t out_q, skid_q, out_d, skid_d, in_e, out_s, skid_s;
  logic irdy_q, irdy_d;
  logic accept, consume;
  logic [NOPS-1:0] in_hit;
  wb_t  w0, w1;

  assign w0 = '{v: bus.wb0_v, rt: bus.wb0_Rt, res: bus.wb0_res};
  assign w1 = '{v: bus.wb1_v, rt: bus.wb1_Rt, res: bus.wb1_res};

  assign accept  = bus.iv & irdy_q;
  assign consume = out_q.v & bus.ordy;

  // Incoming entry: operands resolved against the writeback ports at entry time
  always_comb begin
    in_e      = '0;
    in_e.v    = 1'b1;
    in_e.ir   = bus.iir;
    in_e.tag  = bus.itag;
    in_e.imm  = bus.iimm;
    in_e.r[0] = bus.iRa;
    in_e.r[1] = bus.iRb;
    in_e.r[2] = bus.iRc;
    in_e.x[0] = resolve(bus.iRa, bus.ia, w0, w1);
    in_e.x[1] = resolve(bus.iRb, bus.ib, w0, w1);
    in_e.x[2] = resolve(bus.iRc, bus.ic, w0, w1);
  end

  for (genvar k = 0; k < NOPS; k++) begin : g_hit
    assign in_hit[k] = hit(in_e.r[k], w0, w1);
  end

  assign out_s  = snoop(out_q, w0, w1);
  assign skid_s = snoop(skid_q, w0, w1);

  always_comb begin
    out_d  = out_s;
    skid_d = skid_s;
    if (flush) begin
      out_d.v  = 1'b0;
      skid_d.v = 1'b0;
    end else if (skid_q.v && (!out_q.v || consume)) begin
      out_d    = skid_s;
      skid_d.v = 1'b0;
    end else if (accept && (!out_q.v || consume)) begin
      out_d    = in_e;
    end else if (accept) begin
      skid_d   = in_e;
    end else if (consume) begin
      out_d.v  = 1'b0;
    end
    irdy_d = ~skid_d.v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
      irdy_q <= 1'b1;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
      irdy_q <= irdy_d;
    end
  end

  assign bus.irdy = irdy_q;
  assign bus.ov   = out_q.v;
  assign bus.oir  = out_q.ir;
  assign bus.otag = out_q.tag;
  assign bus.oa   = out_q.x[0];
  assign bus.ob   = out_q.x[1];
  assign bus.oc   = out_q.x[2];
  assign bus.oimm = out_q.imm;

`ifdef RFPHOENIX_OPSTAGE_PERF_EN
  // A forwarded accept still counts when a simultaneous flush drops it: the handshake completed
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (out_q.v && !bus.ordy) stall_cnt <= stall_cnt + 32'd1;
      if (accept && |in_hit)    fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rfphoenix_alu_opstage.sv
// Directed bench for rfphoenix_alu_opstage: streaming, forwarding priority, stall snoop, flush.
module tb_rfphoenix_alu_opstage;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rfphoenix_alu_opstage_if #(.IW(40), .VW(32), .RW(6), .TW(2)) bus ();

`ifdef RFPHOENIX_OPSTAGE_PERF_EN
  logic [31:0] stall_cnt, fwd_cnt;
  rfphoenix_alu_opstage #(.IW(40), .VW(32), .RW(6), .TW(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt));
`else
  rfphoenix_alu_opstage #(.IW(40), .VW(32), .RW(6), .TW(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [39:0] ir, input logic [5:0] ra, input logic [31:0] a,
                       input logic [5:0] rb, input logic [31:0] b,
                       input logic [5:0] rc, input logic [31:0] c);
    bus.iv = 1'b1; bus.iir = ir;
    bus.iRa = ra; bus.ia = a;
    bus.iRb = rb; bus.ib = b;
    bus.iRc = rc; bus.ic = c;
  endtask

  task automatic clr_wb();
    bus.wb0_v = 1'b0; bus.wb0_Rt = '0; bus.wb0_res = '0;
    bus.wb1_v = 1'b0; bus.wb1_Rt = '0; bus.wb1_res = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.iv = 1'b0; bus.iir = '0; bus.itag = '0; bus.iimm = '0;
    bus.iRa = '0; bus.iRb = '0; bus.iRc = '0; bus.ia = '0; bus.ib = '0; bus.ic = '0;
    bus.ordy = 1'b0;
    clr_wb();
    tick(); tick();
    chk("rst_ov", bus.ov, 0);
    chk("rst_irdy", bus.irdy, 1);
    chk("rst_oa", bus.oa, 0);
    chk("rst_oir", bus.oir, 0);
    rst = 1'b0;

    // streaming at one per cycle
    bus.ordy = 1'b1;
    issue(40'h1, 6'd3, 32'h11, 6'd0, 0, 6'd0, 0);
    tick();
    chk("s1_ov", bus.ov, 1);
    chk("s1_oa", bus.oa, 32'h11);
    chk("s1_oir", bus.oir, 40'h1);
    chk("s1_irdy", bus.irdy, 1);
    issue(40'h2, 6'd4, 32'h22, 6'd0, 0, 6'd0, 0);
    tick();
    chk("s2_ov", bus.ov, 1);
    chk("s2_oa", bus.oa, 32'h22);
    chk("s2_oir", bus.oir, 40'h2);
    chk("s2_irdy", bus.irdy, 1);

    // r0 reads zero even with a writeback to r0
    issue(40'h3, 6'd0, 32'hFFFF_FFFF, 6'd0, 0, 6'd0, 0);
    bus.wb0_v = 1'b1; bus.wb0_Rt = 6'd0; bus.wb0_res = 32'h5555;
    tick();
    chk("r0_oa", bus.oa, 32'h0);

    // wb0 beats wb1 on the same register
    issue(40'h4, 6'd0, 0, 6'd5, 32'h1, 6'd0, 0);
    bus.wb0_v = 1'b1; bus.wb0_Rt = 6'd5; bus.wb0_res = 32'hAAAA;
    bus.wb1_v = 1'b1; bus.wb1_Rt = 6'd5; bus.wb1_res = 32'hBBBB;
    tick();
    chk("prio_ob", bus.ob, 32'hAAAA);

    // wb1 alone, wb0 to another operand, imm/tag pass-through
    issue(40'h5, 6'd0, 0, 6'd9, 32'h1, 6'd8, 32'h3);
    bus.itag = 2'd2; bus.iimm = 32'h1234_5678;
    bus.wb0_v = 1'b1; bus.wb0_Rt = 6'd8; bus.wb0_res = 32'hAAAA;
    bus.wb1_v = 1'b1; bus.wb1_Rt = 6'd9; bus.wb1_res = 32'hCCCC;
    tick();
    chk("wb1_ob", bus.ob, 32'hCCCC);
    chk("wb0_oc", bus.oc, 32'hAAAA);
    chk("imm", bus.oimm, 32'h1234_5678);
    chk("tag", bus.otag, 2);
    clr_wb();
    bus.itag = '0; bus.iimm = '0;
    bus.iv = 1'b0;
    tick();
    chk("drain_ov", bus.ov, 0);
    chk("drain_irdy", bus.irdy, 1);

    // stall: fill OUT and SKID, snoop wb1 into both, drain in order
    bus.ordy = 1'b0;
    issue(40'h10, 6'd7, 32'h70, 6'd0, 0, 6'd0, 0);
    tick();
    chk("st_i1_oir", bus.oir, 40'h10);
    chk("st_i1_oa", bus.oa, 32'h70);
    chk("st_i1_irdy", bus.irdy, 1);
    issue(40'h11, 6'd0, 0, 6'd0, 0, 6'd7, 32'h77);
    tick();
    chk("st_full_irdy", bus.irdy, 0);
    chk("st_full_oir", bus.oir, 40'h10);
    bus.iv = 1'b0;
    bus.wb1_v = 1'b1; bus.wb1_Rt = 6'd7; bus.wb1_res = 32'h1234;
    tick();
    clr_wb();
    chk("st_snoop_oa", bus.oa, 32'h1234);
    chk("st_snoop_irdy", bus.irdy, 0);
    bus.ordy = 1'b1;
    tick();
    chk("st_i2_ov", bus.ov, 1);
    chk("st_i2_oir", bus.oir, 40'h11);
    chk("st_i2_oc", bus.oc, 32'h1234);
    chk("st_i2_irdy", bus.irdy, 1);
    tick();
    chk("st_done_ov", bus.ov, 0);

    // flush with both entries held and iv asserted
    bus.ordy = 1'b0;
    issue(40'h20, 6'd1, 32'h1, 6'd0, 0, 6'd0, 0);
    tick();
    issue(40'h21, 6'd1, 32'h2, 6'd0, 0, 6'd0, 0);
    tick();
    chk("fl_full_irdy", bus.irdy, 0);
    issue(40'h22, 6'd1, 32'h3, 6'd0, 0, 6'd0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.iv = 1'b0;
    chk("fl_ov", bus.ov, 0);
    chk("fl_irdy", bus.irdy, 1);
    bus.ordy = 1'b1;
    tick();
    chk("fl_nostale_ov", bus.ov, 0);

    // flush wins over a simultaneous accept
    issue(40'h30, 6'd1, 32'h4, 6'd0, 0, 6'd0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.iv = 1'b0;
    chk("fla_ov", bus.ov, 0);
    tick();
    chk("fla_ov2", bus.ov, 0);
    chk("fla_irdy", bus.irdy, 1);

`ifdef RFPHOENIX_OPSTAGE_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("pf_rst_stall", stall_cnt, 0);
    chk("pf_rst_fwd", fwd_cnt, 0);
    bus.ordy = 1'b0;
    issue(40'h40, 6'd2, 32'h1, 6'd0, 0, 6'd0, 0);
    bus.wb0_v = 1'b1; bus.wb0_Rt = 6'd2; bus.wb0_res = 32'h9;
    tick();
    bus.iv = 1'b0;
    clr_wb();
    tick(); tick(); tick();
    bus.ordy = 1'b1;
    tick();
    chk("pf_stall3", stall_cnt, 3);
    issue(40'h41, 6'd0, 0, 6'd4, 32'h1, 6'd0, 0);
    bus.wb1_v = 1'b1; bus.wb1_Rt = 6'd4; bus.wb1_res = 32'h8;
    tick();
    bus.iv = 1'b0;
    clr_wb();
    tick();
    chk("pf_fwd2", fwd_cnt, 2);
    chk("pf_stall_keep", stall_cnt, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf_flush_stall", stall_cnt, 3);
    chk("pf_flush_fwd", fwd_cnt, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("pf_clr_stall", stall_cnt, 0);
    chk("pf_clr_fwd", fwd_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rfphoenix_alu_opstage.md
Name: rfphoenix_alu_opstage

Overview:
- Operand-latch stage that sits directly upstream of the integer/FP ALU.
- Captures the issued instruction, register-file read data and immediate, and applies result forwarding from two writeback ports.
- Zeroes register 0 operands and presents registered operands (a, b, c, imm, ir) to the ALU through a 2-entry skid buffer with valid/ready handshake.
- Held entries keep snooping writebacks while stalled, so operands are always current when the ALU consumes them.

Parameters:
- IW, 40, instruction width in bits.
- VW, 32, operand/value width in bits.
- RW, 6, register number width (2**RW architectural registers; register 0 reads as zero).
- TW, 2, thread/tag width carried alongside the instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries.
- iv  in  1  issue valid.
- irdy  out  1  stage can accept; registered, equals ~skid_v.
- iir  in  IW  instruction.
- itag  in  TW  thread tag.
- iRa / iRb / iRc  in  RW each  source register numbers.
- ia / ib / ic  in  VW each  register-file read data.
- iimm  in  VW  decoded immediate.
- wb0_v, wb0_Rt, wb0_res  in  1/RW/VW  writeback port 0 (youngest; higher priority).
- wb1_v, wb1_Rt, wb1_res  in  1/RW/VW  writeback port 1.
- ov  out  1  output valid.
- ordy  in  1  ALU accepts.
- oir  out  IW  instruction.
- otag  out  TW  tag.
- oa / ob / oc  out  VW each  operands.
- oimm  out  VW  immediate.

Behaviour:
- Storage: two entries, OUT (drives the o* ports) and SKID. Each holds v, ir, tag, Ra/Rb/Rc, a/b/c and imm.
- Handshake events:
  - accept = iv & irdy.
  - consume = ov & ordy.
  - Both are evaluated on the rising clock edge.
- Operand resolution for an incoming entry, per operand X in {a,b,c}:
  - Rx == 0 gives 0.
  - Otherwise, wb0_v & wb0_Rt == Rx gives wb0_res.
  - Otherwise, wb1_v & wb1_Rt == Rx gives wb1_res.
  - Otherwise, the register-file value.
  - imm passes through unmodified.
- Snooping of held entries: every cycle, each valid held entry (OUT and SKID) with Rx != 0 applies the same wb0 > wb1 priority match and updates its operand in place.
  - This also applies to the OUT entry in a cycle where it is consumed. That update is harmless because the entry leaves.
- Next-state rules, in priority order:
  - rst or flush: OUT.v = 0, SKID.v = 0. All data registers reset to 0 on rst only; flush leaves data as is.
  - SKID.v & (~OUT.v | consume): OUT gets SKID (with snoop applied), and SKID.v = 0. No accept is possible because irdy = 0.
  - accept & (~OUT.v | consume): OUT gets the new entry.
  - accept & OUT.v & ~consume: SKID gets the new entry. irdy drops the following cycle.
  - consume with no new entry: OUT.v = 0.
- Timing: latency from accept to ov is 1 cycle. Throughput is 1 per cycle while ordy = 1.
- irdy is a register: it is 1 after reset and 0 only while SKID.v = 1. It never depends combinationally on ordy.
- Output values while ov = 0 are don't-care. The implementation holds the last values.
- Reset values: ov = 0, irdy = 1, and oir, otag, oa, ob, oc, oimm = 0.
- Simultaneous flush and accept: flush wins and the accepted instruction is dropped. The issuer treats the accept handshake as complete.
- Ordering: entries leave in arrival order, and SKID is never bypassed.

Optional Feature:
- Macro: RFPHOENIX_OPSTAGE_PERF_EN.
- When defined, adds the following outputs:
  - stall_cnt (out, 32): increments each cycle with ov & ~ordy.
  - fwd_cnt (out, 32): increments once per accepted entry in which at least one operand was taken from a writeback port at entry time.
  - Both are cleared by rst, not by flush, and wrap at 2**32.
- When undefined, neither port nor counter exists, and the remaining behaviour is identical.

Test Plan:
- Reset, then iv=1, iRa=3, ia=0x11, ordy=1 -> one cycle later ov=1, oa=0x11. Back-to-back issues stream at 1 per cycle with irdy held at 1.
- iRa=0, ia=0xFFFFFFFF, and wb0_v=1 with wb0_Rt=0 -> oa=0.
- iRb=5, ib=0x1, wb0_v=1, wb0_Rt=5, wb0_res=0xAAAA, and wb1_v=1, wb1_Rt=5, wb1_res=0xBBBB -> ob=0xAAAA (wb0 priority).
- ordy=0 with two issues (I1 Ra=7, I2 Rc=7) -> irdy=0 after the second accept. Then drive wb1_v=1, wb1_Rt=7, wb1_res=0x1234 during the stall, then ordy=1 -> I1 oa=0x1234, then I2 oc=0x1234, in order, and irdy returns to 1.
- Both entries held, flush=1 with iv=1 in the same cycle -> next cycle ov=0, irdy=1, and no stale instruction is ever presented.
- Perf build: 3 stall cycles plus 2 forwarded accepts -> stall_cnt=3, fwd_cnt=2. A flush leaves both counts unchanged and rst clears them.
